// File: rtl/add_rsp.sv
// add_rsp: registered adder responder. Operand pairs come in over a valid/ready handshake
// and their sums are buffered in a small FIFO, then returned in order. ADD_RSP_CNT_EN adds o_txn_count.
module add_rsp #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH:0]   o_sum
`ifdef ADD_RSP_CNT_EN
  ,output logic [7:0]      o_txn_count
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready. Ready never
  // depends on the partner's valid, and valid never depends on the partner's ready.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [WIDTH:0]  r_last;
  logic            w_push;
  logic            w_pop;
  logic [WIDTH:0]  w_sum_in;

  // Both flags come from registered occupancy only; no path from i_out_ready to o_in_ready.
  assign o_in_ready  = (r_count != FULL);
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_sum_in    = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum       = o_out_valid ? r_mem[r_rptr] : r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_sum_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

`ifdef ADD_RSP_CNT_EN
  logic [7:0] r_txn;

  // Counts completed pops and wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_txn <= '0;
    else if (w_pop) r_txn <= r_txn + 8'd1;
  end

  assign o_txn_count = r_txn;
`endif

endmodule

// File: doc/add_rsp.md
# add_rsp

Registered responder for the 4-bit adder operand interface: it accepts `a`/`b` operand pairs from a stimulus driver over a valid/ready handshake, computes `a + b`, and returns each `sum` in order over a second valid/ready handshake. It sits on the DUT side of the adder interface, so a testbench driver can exercise back-pressure, buffering and ordering rather than only combinational settling. An internal result FIFO decouples the accept rate from the drain rate.

## Interface
- `WIDTH`, default 4: operand width; `sum` is `WIDTH+1` bits.
- `DEPTH`, default 2: result FIFO entries; must be a power of two, ≥ 2.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: driver presents a valid operand pair.
- `in_ready`  output  1: responder can accept a pair this cycle.
- `a`  input  WIDTH: operand A; sampled only on accept.
- `b`  input  WIDTH: operand B; sampled only on accept.
- `out_valid`  output  1: `sum` holds a valid result.
- `out_ready`  input  1: consumer takes the result this cycle.
- `sum`  output  WIDTH+1: result at the FIFO head.
- `txn_count`  output  8: completed-result counter; present only with `ADD_RSP_CNT_EN`.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. The responder writes `{1'b0,a} + {1'b0,b}`, which is full width and cannot overflow, into the FIFO tail.
- Drain: `out_valid && out_ready` at a rising edge pops the FIFO head.
- `in_ready = (count != DEPTH)`.
  - Depends only on the registered occupancy, so there is no combinational path from `out_ready`.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- `out_valid = (count != 0)`.
- `sum` = head entry when `out_valid`; otherwise it holds the last popped value, or 0 after reset.
- Results leave in exactly accept order.
- Occupancy `count` ranges 0..DEPTH.
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle (count in 1..DEPTH−1): unchanged.
- Read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
- The FIFO has no full/empty flag beyond `count`.
- Operand changes while `in_valid` is low, or while `in_ready` is low, are ignored.
- A driver may drop `in_valid` without a handshake; the responder has no protocol error checking.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `txn_count`=0, `count`=0, pointers=0.
- Reset asserted mid-operation clears all buffered results immediately; in-flight data is lost.
- Latency: a pair accepted at edge N is visible on `sum` with `out_valid`=1 after edge N; the consumer can pop it at edge N+1.
  - Minimum accept-to-pop is 1 cycle.
- Throughput: one accept and one pop per cycle sustained while `out_ready`=1.
- `in_ready` and `out_valid` are pure functions of registered state.

## Configuration
- Macro: `ADD_RSP_CNT_EN`.
- Defined:
  - The `txn_count` port and an 8-bit counter exist.
  - The counter increments on every pop and wraps 255→0.
  - It resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles → `in_ready`=1, `out_valid`=0, `sum`=0; with the macro defined, `txn_count`=0.
- Single transaction: accept a=4, b=4 with `out_ready`=1 → next cycle `out_valid`=1, `sum`=8; popped the following edge, then `out_valid`=0.
- Ordered stream under full throughput: pairs (4,4), (3,4), (3,7), (15,15) back-to-back with `out_ready`=1 → sums 8, 7, 10, 30 in order, one per cycle.
- Back-pressure/full: `out_ready`=0, offer (1,2), (5,6), (9,9) →
  - first two accepted, `in_ready`=0 after the second, third held off;
  - with `out_ready`=1 and `in_valid` still high, the same cycle pops 3 with no push, the next cycle pops 11 and pushes (9,9), and then 18 is popped.
- Reset mid-operation: two results buffered, assert `rst` asynchronously between edges → `out_valid` drops to 0 and `in_ready` rises to 1 without waiting for a clock edge; stale sums never appear.
- Counter wrap (macro defined): 256 transactions → `txn_count` reads 255 after the 255th pop and 0 after the 256th.
